// File: rtl/silly_synth_pkg.sv
// rtl/silly_synth_pkg.sv - keypad bit layout, song entry format and sequencer states
// Keypad vector: {oct_up[16], oct_down[15], mode[14], goof[13], keys[12:0]}.
// Song entry: {code[3:0], len[3:0]}; len=0 terminates the song.
package silly_synth_pkg;

    localparam int KP_WIDTH    = 17;
    localparam int KP_OCT_UP   = 16;
    localparam int KP_OCT_DOWN = 15;
    localparam int KP_MODE     = 14;
    localparam int KP_GOOF     = 13;
    localparam int KP_KEY0     = 0;

    typedef enum logic [3:0] {
        CODE_GOOF   = 4'd13,
        CODE_OCT_UP = 4'd14,
        CODE_REST   = 4'd15
    } code_e;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] len;
    } song_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRESS,
        GAP,
        DONE
    } state_e;

    // The song table can never press oct_down or mode; masking keeps that guaranteed.
    localparam logic [KP_WIDTH-1:0] KP_AUTOPLAY_MASK =
        ~((KP_WIDTH'(1) << KP_OCT_DOWN) | (KP_WIDTH'(1) << KP_MODE));

    // Entry code -> one-hot keypad vector (all zero for a rest).
    function automatic logic [KP_WIDTH-1:0] code_to_keypad(input logic [3:0] code);
        logic [KP_WIDTH-1:0] kp;
        kp = '0;
        if (code == CODE_GOOF) begin
            kp = KP_WIDTH'(1) << KP_GOOF;
        end else if (code == CODE_OCT_UP) begin
            kp = KP_WIDTH'(1) << KP_OCT_UP;
        end else if (code != CODE_REST) begin
            kp = (KP_WIDTH'(1) << KP_KEY0) << code;
        end
        return kp & KP_AUTOPLAY_MASK;
    endfunction

endpackage

// File: rtl/autoplay_sequencer_if.sv
// rtl/autoplay_sequencer_if.sv - control/keypad bundle between sequencer and top level
// master: sequencer side (receives start/stop/loop_en, drives keypad/busy/done/note_idx)
// slave : controller side
interface autoplay_sequencer_if
    import silly_synth_pkg::*;
#(
    parameter int DEPTH = 64
) ();

    logic                     start;
    logic                     stop;
    logic                     loop_en;
    logic [KP_WIDTH-1:0]      keypad;
    logic                     busy;
    logic                     done;
    logic [$clog2(DEPTH)-1:0] note_idx;

    modport master (
        input  start, stop, loop_en,
        output keypad, busy, done, note_idx
    );

    modport slave (
        output start, stop, loop_en,
        input  keypad, busy, done, note_idx
    );

endinterface

// File: rtl/note_player_rom.sv
// rtl/note_player_rom.sv - combinational song table, address -> song entry
// i_addr  : table index
// o_entry : {code, len}; len=0 is the terminator
module note_player_rom
    import silly_synth_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] i_addr,
    output song_entry_t   o_entry
);

    // Hex digits read {code, len}.
    always_comb begin
        o_entry = '0;
        case (int'(i_addr))
            0:  o_entry = 8'h02;
            1:  o_entry = 8'h42;
            2:  o_entry = 8'h72;
            3:  o_entry = 8'hF1;
            4:  o_entry = 8'hC1;
            5:  o_entry = 8'hD1;
            6:  o_entry = 8'hE1;
            7:  o_entry = 8'h11;
            8:  o_entry = 8'h22;
            9:  o_entry = 8'h31;
            10: o_entry = 8'h51;
            11: o_entry = 8'h61;
            12: o_entry = 8'h82;
            13: o_entry = 8'h91;
            14: o_entry = 8'hA1;
            15: o_entry = 8'hB1;
            16: o_entry = 8'h01;
            17: o_entry = 8'h21;
            18: o_entry = 8'h41;
            19: o_entry = 8'hF1;
            20: o_entry = 8'h73;
            21: o_entry = 8'h51;
            22: o_entry = 8'h31;
            23: o_entry = 8'h11;
            24: o_entry = 8'hC2;
            25: o_entry = 8'hD1;
            26: o_entry = 8'hE1;
            27: o_entry = 8'h02;
            28: o_entry = 8'h41;
            29: o_entry = 8'h71;
            30: o_entry = 8'hF1;
            31: o_entry = 8'h04;
            default: o_entry = '0;
        endcase
    end

endmodule

// File: rtl/autoplay_sequencer.sv
// rtl/autoplay_sequencer.sv - plays the song table as timed keypad presses
// clk  : system clock
// nrst : synchronous active-low reset
// bus  : master side of autoplay_sequencer_if
//        start/stop pulses, loop_en level in; keypad, busy, done pulse, note_idx out
module autoplay_sequencer
    import silly_synth_pkg::*;
#(
    parameter int BEAT_CYCLES = 2_500_000,
    parameter int GAP_CYCLES  = 50_000,
    parameter int DEPTH       = 64
) (
    input  logic                 clk,
    input  logic                 nrst,
    autoplay_sequencer_if.master bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(15 * BEAT_CYCLES + 1);

    if (GAP_CYCLES < 1 || GAP_CYCLES >= BEAT_CYCLES) begin : g_bad_gap
        $error("autoplay_sequencer: need 1 <= GAP_CYCLES < BEAT_CYCLES");
    end

    state_e              r_state;
    logic [KP_WIDTH-1:0] r_keypad;
    logic                r_busy;
    logic                r_done;
    logic [AW-1:0]       r_note_idx;
    logic [CW-1:0]       r_cnt;
    logic                r_wrap;   // index rolled past DEPTH-1: next LOAD acts as terminator

    song_entry_t         w_entry;
    logic [CW-1:0]       w_press_cycles;

    note_player_rom #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rom (
        .i_addr  (r_note_idx),
        .o_entry (w_entry)
    );

    // Press time leaves room for the release gap so the whole note spans len beats.
    assign w_press_cycles = CW'(w_entry.len) * CW'(BEAT_CYCLES) - CW'(GAP_CYCLES);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_keypad   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_note_idx <= '0;
            r_cnt      <= '0;
            r_wrap     <= 1'b0;
        end else if (bus.stop) begin
            // Abort wins over any start; note_idx is left where playback stopped.
            r_state  <= IDLE;
            r_keypad <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state    <= LOAD;
                        r_note_idx <= '0;
                        r_busy     <= 1'b1;
                        r_wrap     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_entry.len != 4'd0 && !r_wrap) begin
                        r_state  <= PRESS;
                        r_keypad <= code_to_keypad(w_entry.code);
                        r_cnt    <= w_press_cycles;
                    end else if (bus.loop_en && (r_note_idx != '0 || r_wrap)) begin
                        // Spend one more LOAD cycle so entry 0 is read fresh.
                        r_note_idx <= '0;
                        r_wrap     <= 1'b0;
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_wrap  <= 1'b0;
                    end
                end
                PRESS: begin
                    if (r_cnt == CW'(1)) begin
                        r_state  <= GAP;
                        r_keypad <= '0;
                        r_cnt    <= CW'(GAP_CYCLES);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                GAP: begin
                    if (r_cnt == CW'(1)) begin
                        r_state <= LOAD;
                        r_cnt   <= '0;
                        if (r_note_idx == AW'(DEPTH - 1)) begin
                            r_note_idx <= '0;
                            r_wrap     <= 1'b1;
                        end else begin
                            r_note_idx <= r_note_idx + AW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.keypad   = r_keypad;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.note_idx = r_note_idx;

endmodule

// File: tb/tb_autoplay_sequencer.sv
// tb/tb_autoplay_sequencer.sv - self-checking bench for autoplay_sequencer
module tb_autoplay_sequencer;

    localparam int BEAT  = 8;
    localparam int GAP   = 2;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic [16:0] kp;
        logic        busy;
        logic        done;
        logic [5:0]  idx;
    } obs_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];

    // {code, len} per entry; entry 32 terminates the song.
    logic [7:0] song [0:32] = '{
        8'h02, 8'h42, 8'h72, 8'hF1, 8'hC1, 8'hD1, 8'hE1, 8'h11,
        8'h22, 8'h31, 8'h51, 8'h61, 8'h82, 8'h91, 8'hA1, 8'hB1,
        8'h01, 8'h21, 8'h41, 8'hF1, 8'h73, 8'h51, 8'h31, 8'h11,
        8'hC2, 8'hD1, 8'hE1, 8'h02, 8'h41, 8'h71, 8'hF1, 8'h04,
        8'h00
    };

    always #5 clk = ~clk;

    autoplay_sequencer_if #(.DEPTH(DEPTH)) bus ();

    autoplay_sequencer #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .DEPTH       (DEPTH)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    function automatic logic [16:0] key_for(input int code);
        if (code <= 12) return 17'(1) << code;
        if (code == 13) return 17'h02000;
        if (code == 14) return 17'h10000;
        return 17'h00000;
    endfunction

    function automatic obs_t mk(input logic [16:0] kp, input logic busy, input logic done, input int idx);
        return {kp, busy, done, 6'(idx)};
    endfunction

    // Expected outputs for every cycle after start is sampled (element 0 = first cycle after).
    task automatic build_trace(input bit loop, input int max_len);
        int idx;
        int len;
        int code;
        idx = 0;
        exp_q.delete();
        while (exp_q.size() < max_len) begin
            len  = int'(song[idx][3:0]);
            code = int'(song[idx][7:4]);
            exp_q.push_back(mk(17'h0, 1'b1, 1'b0, idx));
            if (len == 0) begin
                if (loop && idx != 0) begin
                    idx = 0;
                    continue;
                end
                exp_q.push_back(mk(17'h0, 1'b0, 1'b1, idx));
                exp_q.push_back(mk(17'h0, 1'b0, 1'b0, idx));
                break;
            end
            for (int i = 0; i < len * BEAT - GAP; i++) exp_q.push_back(mk(key_for(code), 1'b1, 1'b0, idx));
            for (int i = 0; i < GAP; i++) exp_q.push_back(mk(17'h0, 1'b1, 1'b0, idx));
            idx = (idx + 1) % DEPTH;
        end
    endtask

    function automatic obs_t want(input int k);
        if (k < exp_q.size()) return exp_q[k];
        return exp_q[exp_q.size() - 1];
    endfunction

    function automatic obs_t seen();
        return {bus.keypad, bus.busy, bus.done, bus.note_idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_play(input bit loop);
        bus.loop_en = loop;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0; nrst = 1'b0;
        repeat (3) tick();
        nrst = 1'b1;
        tick();
        o = seen();
        n_checks++;
        if (o !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_state got=%h want=%h", o, obs_t'(0));
        end
        bus.stop = 1'b1; tick(); bus.stop = 1'b0; tick();
        o = seen();
        n_checks++;
        if (o !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL stop_in_idle got=%h want=%h", o, obs_t'(0));
        end
    endtask

    task automatic test_first_note();
        obs_t o;
        obs_t w;
        int   cyc;
        int   rest_hot;
        rest_hot = 0;
        build_trace(1'b0, 500);
        start_play(1'b0);
        for (int k = 0; k < 70; k++) begin
            cyc = k + 1;
            o = seen();
            n_checks++;
            if (o !== want(k)) begin
                n_fail++;
                $display("FAIL first_note_trace cyc=%0d got=%h want=%h", cyc, o, want(k));
            end
            if (cyc == 1) begin
                n_checks++;
                if (o.busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise got=%b want=1", o.busy); end
            end
            if (cyc >= 2 && cyc <= 17) begin
                n_checks++;
                if (o.kp !== (cyc <= 15 ? 17'h00001 : 17'h00000)) begin
                    n_fail++;
                    $display("FAIL note0_keypad cyc=%0d got=%h", cyc, o.kp);
                end
            end
            if (cyc == 18) begin
                n_checks++;
                if (o.idx !== 6'd1) begin n_fail++; $display("FAIL note_idx_step got=%0d want=1", o.idx); end
            end
            if (cyc == 19) begin
                n_checks++;
                if (o.kp !== 17'h00010) begin n_fail++; $display("FAIL note1_keypad got=%h want=00010", o.kp); end
            end
            if (cyc >= 52 && cyc <= 60 && o.kp !== 17'h0) rest_hot++;
            tick();
        end
        n_checks++;
        if (rest_hot != 0) begin n_fail++; $display("FAIL rest_entry hot_cycles=%0d want=0", rest_hot); end
        w = mk(17'h0, 1'b0, 1'b0, int'(want(70).idx));
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        o = seen();
        n_checks++;
        if (o !== w) begin n_fail++; $display("FAIL stop_playing got=%h want=%h", o, w); end
    endtask

    task automatic test_full_song();
        obs_t o;
        int   n;
        int   dones;
        dones = 0;
        build_trace(1'b0, 100000);
        n = exp_q.size() + 4;
        start_play(1'b0);
        for (int k = 0; k < n; k++) begin
            o = seen();
            if (o.done === 1'b1) dones++;
            n_checks++;
            if (o !== want(k)) begin
                n_fail++;
                $display("FAIL full_song_trace k=%0d got=%h want=%h", k, o, want(k));
            end
            tick();
        end
        n_checks++;
        if (dones != 1) begin n_fail++; $display("FAIL done_count got=%0d want=1", dones); end
    endtask

    task automatic test_loop();
        obs_t o;
        obs_t w;
        int   prev_idx;
        int   wrapped;
        int   dones;
        prev_idx = 0; wrapped = 0; dones = 0;
        build_trace(1'b1, 450);
        start_play(1'b1);
        for (int k = 0; k < 450; k++) begin
            o = seen();
            if (prev_idx == 32 && o.idx == 6'd0) wrapped++;
            prev_idx = int'(o.idx);
            if (o.done === 1'b1) dones++;
            n_checks++;
            if (o !== want(k)) begin
                n_fail++;
                $display("FAIL loop_trace k=%0d got=%h want=%h", k, o, want(k));
            end
            tick();
        end
        n_checks++;
        if (wrapped != 1 || dones != 0) begin
            n_fail++;
            $display("FAIL loop_wrap wraps=%0d dones=%0d want 1 and 0", wrapped, dones);
        end
        w = mk(17'h0, 1'b0, 1'b0, int'(want(450).idx));
        bus.stop = 1'b1; bus.start = 1'b1; tick(); bus.stop = 1'b0; bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            o = seen();
            n_checks++;
            if (o !== w) begin n_fail++; $display("FAIL stop_beats_start k=%0d got=%h want=%h", k, o, w); end
            tick();
        end
        bus.loop_en = 1'b0;
    endtask

    task automatic test_start_during_press();
        obs_t o;
        obs_t w;
        build_trace(1'b0, 500);
        start_play(1'b0);
        for (int k = 0; k < 150; k++) begin
            o = seen();
            n_checks++;
            if (o !== want(k)) begin
                n_fail++;
                $display("FAIL restart_ignored k=%0d got=%h want=%h", k, o, want(k));
            end
            bus.start = (want(k).kp != 17'h0 && $urandom_range(0, 3) == 0);
            tick();
        end
        bus.start = 1'b0;
        w = mk(17'h0, 1'b0, 1'b0, int'(want(150).idx));
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        o = seen();
        n_checks++;
        if (o !== w) begin n_fail++; $display("FAIL stop_after_restarts got=%h want=%h", o, w); end
    endtask

    task automatic test_random_stop();
        obs_t o;
        obs_t w;
        bit   loop;
        int   n;
        for (int it = 0; it < 4; it++) begin
            loop = 1'($urandom_range(0, 1));
            n    = int'($urandom_range(3, 450));
            build_trace(loop, 460);
            start_play(loop);
            for (int k = 0; k < n; k++) begin
                o = seen();
                n_checks++;
                if (o !== want(k)) begin
                    n_fail++;
                    $display("FAIL rand_trace it=%0d k=%0d got=%h want=%h", it, k, o, want(k));
                end
                tick();
            end
            w = mk(17'h0, 1'b0, 1'b0, int'(want(n).idx));
            bus.stop = 1'b1; tick(); bus.stop = 1'b0;
            for (int k = 0; k < 2; k++) begin
                o = seen();
                n_checks++;
                if (o !== w) begin n_fail++; $display("FAIL rand_stop it=%0d got=%h want=%h", it, o, w); end
                tick();
            end
        end
        bus.loop_en = 1'b0;
    endtask

    task automatic test_reset_mid_press();
        obs_t o;
        build_trace(1'b0, 200);
        start_play(1'b0);
        repeat (6) tick();
        nrst = 1'b0; tick(); nrst = 1'b1;
        o = seen();
        n_checks++;
        if (o !== obs_t'(0)) begin n_fail++; $display("FAIL reset_mid_press got=%h want=%h", o, obs_t'(0)); end
        tick(); tick();
        start_play(1'b0);
        for (int k = 0; k < 40; k++) begin
            o = seen();
            n_checks++;
            if (o !== want(k)) begin
                n_fail++;
                $display("FAIL replay_after_reset k=%0d got=%h want=%h", k, o, want(k));
            end
            tick();
        end
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_full_song();
        test_loop();
        test_start_during_press();
        test_random_stop();
        test_reset_mid_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
